// File: rtl/mem_responder_if.sv
// ---------------------------------------------------------------------------
// mem_responder_if
//   Request/response bundle between the datapath (MAR/MDR side) and the
//   memory responder.
//
//   Handshake: the requester raises Read and/or Write as a level and keeps
//   address/data_in stable until it sees mem_ready. The responder samples the
//   request only while idle, so a request is accepted at the first rising edge
//   where Read|Write is high and the responder is idle. mem_ready (and err, if
//   the access failed) pulse high for exactly one cycle when the access
//   completes. The responder then ignores the bus until Read and Write have
//   both been seen low at an edge, so a held level yields exactly one access.
//   busy is high from the accept edge up to and including the mem_ready cycle.
//
//   Signals
//     Read, Write   requester -> responder  level-sensitive request
//     address       requester -> responder  word address from MAR
//     data_in       requester -> responder  write data from MDR
//     Mdatain       responder -> requester  last read data, to the MDR mux
//     mem_ready     responder -> requester  one-cycle completion pulse
//     busy          responder -> requester  request in service
//     err           responder -> requester  one-cycle error pulse with mem_ready
// ---------------------------------------------------------------------------
interface mem_responder_if #(
   parameter int DATA_W = 32
);
   logic              Read;
   logic              Write;
   logic [31:0]       address;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] Mdatain;
   logic              mem_ready;
   logic              busy;
   logic              err;

   modport master (
      output Read, Write, address, data_in,
      input  Mdatain, mem_ready, busy, err
   );

   modport slave (
      input  Read, Write, address, data_in,
      output Mdatain, mem_ready, busy, err
   );
endinterface

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for the MAR/MDR memory interface. A request is
//   latched when the responder is idle, serviced after WAIT_STATES extra
//   cycles, and completion is flagged with a one-cycle mem_ready pulse so the
//   control sequencer can stall on memory. All outputs are registered.
//
//   Parameters
//     ADDR_W       word-address bits; array depth is 2**ADDR_W words
//     DATA_W       word width
//     WAIT_STATES  extra cycles before an access completes (0..15)
//
//   Ports
//     clk          system clock, rising edge
//     clr          asynchronous active-low reset
//     bus          request/response bundle (slave side), see mem_responder_if
//     dbg_state_o  current FSM state, for debug/observation only
//
//   Error cases (complete with normal latency, err=1 with mem_ready=1):
//     - Read and Write both high at acceptance: no array access.
//     - address bits above ADDR_W non-zero: no array access; a read returns
//       zero on Mdatain, a write is dropped. Addresses never wrap.
// ---------------------------------------------------------------------------
module mem_responder #(
   parameter int ADDR_W      = 9,
   parameter int DATA_W      = 32,
   parameter int WAIT_STATES = 2
) (
   input  logic           clk,
   input  logic           clr,
   mem_responder_if.slave bus,
   output logic [1:0]     dbg_state_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [1:0] S_HOLD = 2'd3;

   localparam int         DEPTH     = 1 << ADDR_W;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

   // FSM and request latches
   logic [1:0]        state_q, state_d;
   logic [3:0]        cnt_q,   cnt_d;
   logic [31:0]       addr_q,  addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              rd_q,    rd_d;
   logic              wr_q,    wr_d;

   // Registered outputs
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              ready_q, ready_d;
   logic              busy_q,  busy_d;
   logic              err_q,   err_d;

   // Storage (deliberately has no reset: contents survive clr)
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              mem_we;

   logic              req;
   logic              in_range;
   logic [ADDR_W-1:0] idx;

   assign req      = bus.Read | bus.Write;
   // Any set bit above the array index makes the access illegal; no wrap.
   assign in_range = (addr_q >> ADDR_W) == '0;
   assign idx      = addr_q[ADDR_W-1:0];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      rdata_d = rdata_q;
      ready_d = 1'b0;
      busy_d  = busy_q;
      err_d   = 1'b0;
      mem_we  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req) begin
               addr_d  = bus.address;
               wdata_d = bus.data_in;
               rd_d    = bus.Read;
               wr_d    = bus.Write;
               cnt_d   = WAIT_INIT;
               busy_d  = 1'b1;
               state_d = S_WAIT;
            end
         end

         S_WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               // The access happens on this edge; its result is visible in DONE.
               state_d = S_DONE;
               ready_d = 1'b1;
               if (rd_q && wr_q) begin
                  err_d = 1'b1;
               end else if (!in_range) begin
                  err_d = 1'b1;
                  if (rd_q) begin
                     rdata_d = '0;
                  end
               end else if (rd_q) begin
                  rdata_d = mem_q[idx];
               end else begin
                  mem_we = wr_q;
               end
            end
         end

         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_HOLD;
         end

         S_HOLD: begin
            // Wait for the requester to drop its level so one request is one access.
            if (!req) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   // While clr is low the FSM is held in IDLE, so mem_we cannot fire and an
   // abandoned write is never committed.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[idx] <= wdata_q;
      end
   end

   assign bus.Mdatain   = rdata_q;
   assign bus.mem_ready = ready_q;
   assign bus.busy      = busy_q;
   assign bus.err       = err_q;
   assign dbg_state_o   = state_q;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the datapath's MAR/MDR memory interface.
- Accepts Read/Write requests, with the address taken from MAR and the write data from MDR.
- Services each request after a programmable number of wait states and returns read data on Mdatain, which feeds the MDR input mux.
- Signals completion with a one-cycle mem_ready pulse, so the control sequencer can stall on memory.

Parameters:
- ADDR_W, 9: word-address bits; array depth is 2**ADDR_W words.
- DATA_W, 32: word width.
- WAIT_STATES, 2: extra cycles before an access completes; legal range 0..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clr  input  1  asynchronous, active-low reset.
- Read  input  1  read request, level-sensitive.
- Write  input  1  write request, level-sensitive.
- address  input  32  word address from MAR.
- data_in  input  DATA_W  write data from MDR.
- Mdatain  output  DATA_W  read data to the MDR mux.
- mem_ready  output  1  one-cycle completion pulse.
- busy  output  1  high while a request is being serviced.
- err  output  1  one-cycle error pulse, coincident with mem_ready.

Behaviour:
- Reset (clr=0, asynchronous):
  - State goes to IDLE; wait counter is 0.
  - Mdatain=0, mem_ready=0, busy=0, err=0.
  - The memory array is not cleared.
  - Reset mid-request abandons the request; a pending write is not performed.
- States: IDLE, WAIT, DONE, HOLD. All outputs are registered.
- IDLE:
  - Exits when Read|Write is sampled high at an edge.
  - Latches address, data_in and op; loads the counter with WAIT_STATES; goes to WAIT; busy=1.
- WAIT:
  - Each edge with counter!=0 decrements the counter.
  - The edge with counter==0 performs the access and goes to DONE.
  - Read: Mdatain <= mem[addr[ADDR_W-1:0]].
  - Write: mem[addr] <= latched data; Mdatain is unchanged.
- DONE:
  - mem_ready=1 for exactly this cycle; busy stays 1.
  - The next edge goes to HOLD with mem_ready=0.
- HOLD:
  - busy=0.
  - Stays in HOLD while Read|Write is high; goes to IDLE at the first edge with both low.
  - A level request therefore produces exactly one access.
- Latency: for a request accepted at edge E, mem_ready is high during the cycle after edge E+WAIT_STATES+1. With WAIT_STATES=2, mem_ready rises at edge E+3.
- Mdatain holds the last read value until the next read completes or reset.
- Inputs are ignored outside IDLE: changes to address, data_in or op after acceptance have no effect.
- Read and Write both high at acceptance:
  - Error request; no array access; Mdatain unchanged.
  - Completes with normal latency, with err=1 and mem_ready=1 in DONE.
- Out-of-range address (address[31:ADDR_W] != 0):
  - No array access.
  - A read sets Mdatain=0; a write is discarded.
  - err=1 and mem_ready=1 in DONE.
- Address wrap-around is never applied; out-of-range is always an error.
- WAIT_STATES=0: the access occurs at edge E+1.
- Read-after-write to the same address returns the new data.

Test Plan:
- Reset and write: clr=0, then release; write 0xDEADBEEF to 0x010.
  - busy rises after the accept edge; mem_ready pulses one cycle, 3 edges after accept; err=0.
- Read back: Read with address=0x010.
  - Mdatain=0xDEADBEEF when mem_ready=1, and it holds after the pulse.
- Level hold: Read held high for 10 cycles on 0x010.
  - Exactly one mem_ready pulse; FSM stays in HOLD until Read=0; a second request is then accepted.
- Errors:
  - Read with address=0x00000200 -> err=1 with mem_ready, Mdatain=0.
  - Read=Write=1 on address 0x010 -> err=1, and mem[0x010] is still 0xDEADBEEF on a later read.
- Reset mid-request: write 0x12345678 to 0x020, assert clr=0 during WAIT.
  - Outputs go to 0 immediately; a later read of 0x020 does not return 0x12345678.
- Zero wait states: WAIT_STATES=0, write 0x5 to 0x001, then read 0x001.
  - mem_ready 1 edge after each accept; Mdatain=0x00000005.
